hb_period_meter: RTL and testbench

Heartbeat period front end for the watchdog reciprocal stage. It synchronises an external heartbeat and measures the clock-cycle interval between rising edges. It keeps a running average of the last 2^AVG_LOG2 periods, converts that average to a signed QF time value, and drives the start_calc / done handshake of the downstream inv_recip, which turns the period into a rate. A missing heartbeat raises a sticky timeout and forces one zero-period calculation, so the rate stage reports invalid / rate 0.

---
 rtl/hb_period_meter.sv | 182 ++++++++++++++++++
 tb/tb_hb_period_meter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_period_meter.sv
// Heartbeat period meter: synchronises hb_in, averages edge-to-edge periods,
// converts the average to a QF time value and issues inv_recip requests.
module hb_period_meter #(
    parameter int W        = 32,
    parameter int F        = 16,
    parameter int CNT_W    = 24,
    parameter int AVG_LOG2 = 2,
    parameter int TB_LOG2  = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         hb_in,
    output logic         start_calc,
    input  logic         done,
    output logic [W-1:0] x_in,
    output logic         period_valid,
    output logic         timeout,
    output logic         busy
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int RD = 1 << PW;
    localparam int FW = AVG_LOG2 + 1;
    localparam int SW = CNT_W + AVG_LOG2;
    localparam int SH = F - TB_LOG2;
    localparam int QW = (CNT_W + SH > W + 1) ? CNT_W + SH : W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } st_t;

    st_t              st, st_nx;
    logic             s1, s2, s3;
    logic             hb_edge;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             capture;
    logic             to_hit;
    logic             load;
    logic             pend, pend_to;
    logic [FW-1:0]    fill, fill_nx;
    logic [SW-1:0]    sum, sum_nx;
    logic [PW-1:0]    wp, wp_nx;
    logic [CNT_W-1:0] ring [RD];
    logic [CNT_W-1:0] evict;
    logic [CNT_W-1:0] avg;
    logic [QW-1:0]    q_wide;
    logic [W-1:0]     q, q_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= hb_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign hb_edge = s2 & ~s3;
    assign capture = enable & hb_edge & armed;
    assign to_hit  = enable & ~hb_edge & (cnt == CNT_W'(TIMEOUT));
    assign load    = (st == S_IDLE) & pend & enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (hb_edge) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Evicted slots read as zero until the window has filled once.
    assign evict   = (fill == FW'(N)) ? ring[wp] : '0;
    assign sum_nx  = sum + SW'(cnt) - SW'(evict);
    assign fill_nx = (fill == FW'(N)) ? fill : fill + FW'(1);
    assign wp_nx   = (wp == PW'(N - 1)) ? '0 : wp + PW'(1);

    always_ff @(posedge clk) begin
        if (capture) begin
            ring[wp] <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            timeout <= 1'b0;
            fill    <= '0;
            sum     <= '0;
            wp      <= '0;
            pend    <= 1'b0;
            pend_to <= 1'b0;
        end else if (!enable) begin
            armed   <= 1'b0;
            timeout <= 1'b0;
            fill    <= '0;
            sum     <= '0;
            wp      <= '0;
            pend    <= 1'b0;
            pend_to <= 1'b0;
        end else begin
            if (load) begin
                pend    <= 1'b0;
                pend_to <= 1'b0;
            end
            if (hb_edge) begin
                armed   <= 1'b1;
                timeout <= 1'b0;
                if (armed) begin
                    sum  <= sum_nx;
                    fill <= fill_nx;
                    wp   <= wp_nx;
                    if (fill_nx == FW'(N)) begin
                        pend <= 1'b1;
                    end
                end
            end else if (to_hit) begin
                armed   <= 1'b0;
                timeout <= 1'b1;
                fill    <= '0;
                sum     <= '0;
                wp      <= '0;
                if (!timeout) begin
                    pend    <= 1'b1;
                    pend_to <= 1'b1;
                end
            end
        end
    end

    assign period_valid = (fill == FW'(N));

    assign q_max  = {1'b0, {(W-1){1'b1}}};
    assign avg    = CNT_W'(sum >> AVG_LOG2);
    assign q_wide = QW'(avg) << SH;
    assign q      = (q_wide > QW'(q_max)) ? q_max : q_wide[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            S_IDLE:  if (load) st_nx = S_ISSUE;
            S_ISSUE: st_nx = S_WAIT;
            S_WAIT:  if (done) st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_comb begin
        start_calc = (st == S_ISSUE);
        busy       = (st != S_IDLE);
    end

    // A timeout request forces a zero period so the rate stage reports invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_in <= '0;
        end else if (load) begin
            x_in <= pend_to ? '0 : q;
        end
    end

endmodule

// File: tb/tb_hb_period_meter.sv
// Directed/randomised bench for hb_period_meter with an inv_recip done stub
// and a queue-based averaging reference model.
module tb_hb_period_meter;

    localparam int N   = 4;
    localparam int SHM = 12;
    localparam int TO  = 1000;

    logic        clk = 1'b0;
    logic        rst_n, enable, hb, start_calc, done, pv, to, busy;
    logic [31:0] x_in;
    logic        enable2, hb2, start2, done2, pv2, to2, busy2;
    logic [31:0] x2;
    logic        stub_done, man_done;

    int     checks = 0, errors = 0;
    int     cyc = 0;
    int     sc_count = 0, sc2_count = 0, overlap = 0, xhold = 0;
    int     stub_left = 0, stub2_left = 0;
    int     n, n0;
    longint last_x = 0, last_x2 = 0;
    longint win[$];
    bit     m_armed;
    longint prev_rise, last_rise, mexp, r1, r2;

    assign done = stub_done | man_done;

    hb_period_meter u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .hb_in(hb),
        .start_calc(start_calc), .done(done), .x_in(x_in),
        .period_valid(pv), .timeout(to), .busy(busy)
    );

    hb_period_meter #(
        .W(32), .F(16), .CNT_W(24), .AVG_LOG2(0),
        .TB_LOG2(0), .TIMEOUT(100000)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .hb_in(hb2),
        .start_calc(start2), .done(done2), .x_in(x2),
        .period_valid(pv2), .timeout(to2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // inv_recip stubs: main answers 12 cycles after start_calc, sat after 3
    initial begin
        stub_done = 1'b0;
        done2 = 1'b0;
        forever begin
            @(negedge clk);
            stub_done = 1'b0;
            done2 = 1'b0;
            if (!rst_n) begin
                stub_left = 0;
                stub2_left = 0;
            end else begin
                if (start_calc) begin
                    sc_count++;
                    last_x = x_in;
                    if (stub_left > 0) overlap++;
                    else stub_left = 12;
                end else if (stub_left > 0) begin
                    stub_left--;
                    if (stub_left == 0) begin
                        stub_done = 1'b1;
                        if (x_in !== last_x[31:0]) xhold++;
                    end
                end
                if (start2) begin
                    sc2_count++;
                    last_x2 = x2;
                    if (stub2_left == 0) stub2_left = 3;
                end else if (stub2_left > 0) begin
                    stub2_left--;
                    if (stub2_left == 0) done2 = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_q(input longint a, input int sh);
        longint v;
        v = a << sh;
        if (v > 64'sh7FFFFFFF) v = 64'sh7FFFFFFF;
        return v;
    endfunction

    task automatic model_clear();
        win.delete();
        m_armed = 1'b0;
    endtask

    // Each rising heartbeat either arms or pushes the interval since the last one.
    task automatic model_rise(input longint r);
        longint s;
        if (m_armed && (r - prev_rise) <= TO) begin
            win.push_back(r - prev_rise);
            if (win.size() > N) win.delete(0);
            if (win.size() == N) begin
                s = 0;
                foreach (win[i]) s += win[i];
                mexp = model_q(s / N, SHM);
            end
        end else begin
            win.delete();
        end
        m_armed = 1'b1;
        prev_rise = r;
    endtask

    task automatic beat(input bit sel, input int p);
        @(posedge clk);
        #1;
        if (sel) hb2 = 1'b1;
        else hb = 1'b1;
        last_rise = cyc + 1;
        if (!sel) model_rise(last_rise);
        repeat (p / 2) @(posedge clk);
        #1;
        if (sel) hb2 = 1'b0;
        else hb = 1'b0;
        repeat (p - p / 2 - 1) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; hb = 1'b0;
        enable2 = 1'b0; hb2 = 1'b0; man_done = 1'b0;
        m_armed = 1'b0; mexp = 0; prev_rise = 0; last_rise = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_calc", start_calc, 0);
        chk("rst_x_in", x_in, 0);
        chk("rst_period_valid", pv, 0);
        chk("rst_timeout", to, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        enable = 1'b1;

        repeat (4) beat(0, 100);
        #1;
        chk("pv_after4", pv, win.size() == N);
        chk("sc_after4", sc_count, 0);
        beat(0, 100);
        #1;
        chk("pv_after5", pv, win.size() == N);
        chk("sc_after5", sc_count, 1);
        chk("x_steady", last_x, mexp);

        beat(0, 200);
        beat(0, 100);
        #1;
        chk("sc_step", sc_count, 3);
        chk("x_step", last_x, mexp);

        n0 = sc_count;
        beat(0, 10);
        beat(0, 150);
        #1;
        chk("sc_coalesce", sc_count - n0, 2);
        chk("x_coalesce", last_x, mexp);
        chk("busy_coalesce", busy, 0);

        n0 = sc_count;
        n = 0;
        while (!to && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_set", to, 1);
        chk("to_latency", cyc - last_rise, TO + 2);
        model_clear();
        repeat (20) @(posedge clk);
        #1;
        chk("sc_timeout", sc_count - n0, 1);
        chk("x_timeout", last_x, 0);
        chk("pv_timeout", pv, 0);
        beat(0, 100);
        #1;
        chk("to_cleared", to, 0);
        chk("pv_rearm", pv, 0);
        chk("sc_rearm", sc_count - n0, 1);

        beat(0, 100);
        beat(0, 100);
        #1;
        chk("pv_mid", pv, win.size() == N);
        enable = 1'b0;
        model_clear();
        repeat (20) @(posedge clk);
        #1;
        chk("pv_disabled", pv, 0);
        enable = 1'b1;
        n0 = sc_count;
        for (int i = 0; i < 5; i++) begin
            beat(0, $urandom_range(40, 300));
            #1;
            if (i == 3) chk("sc_3new", sc_count - n0, 0);
        end
        chk("sc_4new", sc_count - n0, 1);
        chk("x_4new", last_x, mexp);
        for (int i = 0; i < 6; i++) begin
            beat(0, $urandom_range(40, 400));
            #1;
            chk("x_rand", last_x, mexp);
        end

        n0 = sc_count;
        @(posedge clk);
        #1;
        hb = 1'b1;
        n = 0;
        while (!start_calc && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sc_pre_reset", start_calc, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_pre_reset", busy, 1);
        hb = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start_calc", start_calc, 0);
        chk("mid_rst_x_in", x_in, 0);
        chk("mid_rst_pv", pv, 0);
        chk("mid_rst_timeout", to, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("sc_after_reset", sc_count - n0, 1);

        enable2 = 1'b1;
        beat(1, 40000);
        r1 = last_rise;
        beat(1, 40);
        r2 = last_rise;
        #1;
        chk("sat_sc", sc2_count, 1);
        chk("sat_x", last_x2, model_q(r2 - r1, 16));
        chk("sat_pv", pv2, 1);

        chk("no_start_while_busy", overlap, 0);
        chk("x_held_to_done", xhold, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
